// File: rtl/game_pkg.sv
// Shared constants for the game flow controller and the player datapath:
// FSM state codes, coordinate width, default spawn point.
package game_pkg;
  localparam int GS_W  = 3;
  localparam int POS_W = 10;

  localparam logic [GS_W-1:0] GS_TITLE   = 3'd0;
  localparam logic [GS_W-1:0] GS_RESPAWN = 3'd1;
  localparam logic [GS_W-1:0] GS_PLAY    = 3'd2;
  localparam logic [GS_W-1:0] GS_DEAD    = 3'd3;
  localparam logic [GS_W-1:0] GS_CLEAR   = 3'd4;

  // Same default spawn the player block uses.
  localparam logic [POS_W-1:0] INIT_X = 10'd200;
  localparam logic [POS_W-1:0] INIT_Y = 10'd556;

  // Death counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/key_edge.sv
// Rising-edge detector: one registered pulse the cycle after a 0->1 level
// change of key; a held key gives a single pulse.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);
  logic prev;

  // Remember last level and register the edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= key;
      pulse <= key & ~prev;
    end
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title/respawn/play/dead/clear flow, player reset and
// freeze, spawn point, death counter and overlay blink.
// Optional macro GAME_FLOW_SAVE_POINT_EN: hit_save in PLAY captures the
// player position as the new spawn point; without it spawn is fixed.
module game_flow_ctrl
  import game_pkg::GS_W, game_pkg::POS_W, game_pkg::GS_TITLE,
         game_pkg::GS_RESPAWN, game_pkg::GS_PLAY, game_pkg::GS_DEAD,
         game_pkg::GS_CLEAR, game_pkg::sat_inc;
#(
  parameter logic [9:0] INIT_X         = game_pkg::INIT_X,
  parameter logic [9:0] INIT_Y         = game_pkg::INIT_Y,
  parameter int         RESPAWN_CYCLES = 16,
  parameter int         BLINK_INV      = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_key,
  input  logic             retry_key,
  input  logic             hit_hazard,
  input  logic             hit_save,
  input  logic             hit_goal,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  output logic             player_rst,
  output logic             player_freeze,
  output logic [POS_W-1:0] spawn_x,
  output logic [POS_W-1:0] spawn_y,
  output logic [GS_W-1:0]  game_state,
  output logic [15:0]      death_count,
  output logic             overlay_blink
);
  localparam logic [7:0]  RESP_LAST  = 8'(RESPAWN_CYCLES - 1);
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_INV - 1);

  logic            start_pe, retry_pe;
  logic [GS_W-1:0] state, next_state;
  logic [7:0]      resp_cnt, resp_cnt_d;
  logic [23:0]     blink_cnt, blink_cnt_d;
  logic            prst_d, freeze_d, blink_d;
  logic [15:0]     death_d;

  key_edge u_start (.clk(clk), .rst(rst), .key(start_key), .pulse(start_pe));
  key_edge u_retry (.clk(clk), .rst(rst), .key(retry_key), .pulse(retry_pe));

  // State, counters and all outputs registered from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= GS_TITLE;
      resp_cnt      <= '0;
      blink_cnt     <= '0;
      player_rst    <= 1'b1;
      player_freeze <= 1'b1;
      death_count   <= '0;
      overlay_blink <= 1'b0;
    end else begin
      state         <= next_state;
      resp_cnt      <= resp_cnt_d;
      blink_cnt     <= blink_cnt_d;
      player_rst    <= prst_d;
      player_freeze <= freeze_d;
      death_count   <= death_d;
      overlay_blink <= blink_d;
    end
  end

  // Next state and death count; PLAY events resolved by priority.
  always_comb begin
    next_state = state;
    death_d    = death_count;
    case (state)
      GS_TITLE: if (start_pe) begin
        next_state = GS_RESPAWN;
        death_d    = '0;
      end
      GS_RESPAWN: if (resp_cnt == RESP_LAST) next_state = GS_PLAY;
      GS_PLAY: begin
        if (hit_hazard) begin
          next_state = GS_DEAD;
          death_d    = sat_inc(death_count);
        end else if (hit_goal) next_state = GS_CLEAR;
        else if (retry_pe)     next_state = GS_RESPAWN;
      end
      GS_DEAD:  if (retry_pe) next_state = GS_RESPAWN;
      GS_CLEAR: if (start_pe) next_state = GS_TITLE;
      default:  next_state = GS_TITLE;
    endcase
  end

  // Output values and counters for the state being entered.
  always_comb begin
    prst_d      = (next_state == GS_TITLE) || (next_state == GS_RESPAWN);
    freeze_d    = (next_state != GS_PLAY);
    resp_cnt_d  = (next_state == GS_RESPAWN && state == GS_RESPAWN) ? resp_cnt + 8'd1 : 8'd0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (next_state == GS_DEAD || next_state == GS_CLEAR) begin
      if (next_state != state) begin
        blink_d = 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_d = ~overlay_blink;
      end else begin
        blink_cnt_d = blink_cnt + 24'd1;
        blink_d     = overlay_blink;
      end
    end
  end

  assign game_state = state;

`ifdef GAME_FLOW_SAVE_POINT_EN
  // Spawn reloads default on game start, captures position on a save hit
  // that no higher-priority PLAY event overrides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spawn_x <= INIT_X;
      spawn_y <= INIT_Y;
    end else if (state == GS_TITLE && start_pe) begin
      spawn_x <= INIT_X;
      spawn_y <= INIT_Y;
    end else if (state == GS_PLAY && next_state == GS_PLAY && hit_save) begin
      spawn_x <= pos_x;
      spawn_y <= pos_y;
    end
  end
`else
  assign spawn_x = INIT_X;
  assign spawn_y = INIT_Y;
  logic unused_save;
  assign unused_save = ^{hit_save, pos_x, pos_y};
`endif
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_game_flow_ctrl;
  localparam int RC = 16;
  localparam int BI = 4;
  localparam int IX = 200;
  localparam int IY = 556;

  logic clk = 1'b0, rst = 1'b0;
  logic start_key = 1'b0, retry_key = 1'b0;
  logic hit_hazard = 1'b0, hit_save = 1'b0, hit_goal = 1'b0;
  logic [9:0] pos_x = '0, pos_y = '0;
  logic player_rst, player_freeze, overlay_blink;
  logic [9:0] spawn_x, spawn_y;
  logic [2:0] game_state;
  logic [15:0] death_count;

  int checks = 0, errors = 0;

  // Model: 0 title, 1 respawn, 2 play, 3 dead, 4 clear
  int m_state, m_age, m_deaths, m_sx, m_sy;
  bit m_sprev, m_spe, m_rprev, m_rpe;

  game_flow_ctrl #(.RESPAWN_CYCLES(RC), .BLINK_INV(BI)) dut (
    .clk(clk), .rst(rst), .start_key(start_key), .retry_key(retry_key),
    .hit_hazard(hit_hazard), .hit_save(hit_save), .hit_goal(hit_goal),
    .pos_x(pos_x), .pos_y(pos_y), .player_rst(player_rst),
    .player_freeze(player_freeze), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .game_state(game_state), .death_count(death_count),
    .overlay_blink(overlay_blink)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_age = 0; m_deaths = 0; m_sx = IX; m_sy = IY;
    m_sprev = 0; m_spe = 0; m_rprev = 0; m_rpe = 0;
  endfunction

  // Advance the model one clock using the inputs currently applied.
  function automatic void model_eval();
    int nxt;
    nxt = m_state;
    case (m_state)
      0: if (m_spe) begin nxt = 1; m_deaths = 0; m_sx = IX; m_sy = IY; end
      1: if (m_age == RC - 1) nxt = 2;
      2: begin
        if (hit_hazard) begin
          nxt = 3;
          if (m_deaths < 65535) m_deaths = m_deaths + 1;
        end else if (hit_goal) nxt = 4;
        else if (m_rpe) nxt = 1;
        else if (hit_save) begin
`ifdef GAME_FLOW_SAVE_POINT_EN
          m_sx = int'(pos_x); m_sy = int'(pos_y);
`endif
        end
      end
      3: if (m_rpe) nxt = 1;
      4: if (m_spe) nxt = 0;
      default: nxt = 0;
    endcase
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
    m_spe   = start_key && !m_sprev; m_sprev = start_key;
    m_rpe   = retry_key && !m_rprev; m_rprev = retry_key;
  endfunction

  function automatic logic [41:0] model_out();
    logic e_rst, e_frz, e_blk;
    e_rst = (m_state <= 1);
    e_frz = (m_state != 2);
    e_blk = (m_state >= 3) && (((m_age / BI) % 2) == 0);
    return {3'(m_state), e_rst, e_frz, 10'(m_sx), 10'(m_sy), 16'(m_deaths), e_blk};
  endfunction

  task automatic step();
    model_eval();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start_key = 0; retry_key = 0; hit_hazard = 0; hit_goal = 0; hit_save = 0;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (game_state !== s && n < budget) begin step(); n++; end
    checks++;
    if (game_state !== s) begin
      errors++;
      $display("FAIL wait_state got state %0d want %0d after %0d cycles", game_state, s, n);
    end
  endtask

  task automatic pulse_key(input bit is_start);
    if (is_start) start_key = 1; else retry_key = 1;
    step(); step();
    start_key = 0; retry_key = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", game_state); end
    checks++; if (player_rst !== 1'b1) begin errors++; $display("FAIL reset_prst got %b want 1", player_rst); end
    checks++; if (player_freeze !== 1'b1) begin errors++; $display("FAIL reset_freeze got %b want 1", player_freeze); end
    checks++; if (spawn_x !== 10'd200 || spawn_y !== 10'd556) begin errors++; $display("FAIL reset_spawn got %0d,%0d want 200,556", spawn_x, spawn_y); end
    checks++; if (death_count !== 16'd0) begin errors++; $display("FAIL reset_deaths got %0d want 0", death_count); end
    checks++; if (overlay_blink !== 1'b0) begin errors++; $display("FAIL reset_blink got %b want 0", overlay_blink); end
  endtask

  task automatic test_start_respawn();
    int n_resp, n;
    n_resp = 0;
    start_key = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (game_state === 3'd1 && player_rst === 1'b1) n_resp++;
    end
    start_key = 0;
    n = 0;
    while (game_state !== 3'd2 && n < 40) begin
      step(); n++;
      if (game_state === 3'd1 && player_rst === 1'b1) n_resp++;
    end
    checks++; if (n_resp !== RC) begin errors++; $display("FAIL respawn_len got %0d want %0d", n_resp, RC); end
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL play_entry got %0d want 2", game_state); end
    checks++; if (player_rst !== 1'b0 || player_freeze !== 1'b0) begin errors++; $display("FAIL play_ctrl got rst=%b frz=%b want 0,0", player_rst, player_freeze); end
    checks++; if (spawn_x !== 10'd200 || spawn_y !== 10'd556 || death_count !== 16'd0) begin errors++; $display("FAIL play_init got %0d,%0d d=%0d want 200,556 d=0", spawn_x, spawn_y, death_count); end
    // A held key gave one pulse: no second start effect, still PLAY a bit later.
    step(); step();
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL held_key got %0d want 2", game_state); end
  endtask

  task automatic test_hazard_deaths();
    hit_hazard = 1; hit_goal = 1; step(); hit_hazard = 0; hit_goal = 0;
    checks++; if (game_state !== 3'd3 || death_count !== 16'd1) begin errors++; $display("FAIL hazard_prio got s=%0d d=%0d want s=3 d=1", game_state, death_count); end
    checks++; if (player_rst !== 1'b0 || player_freeze !== 1'b1) begin errors++; $display("FAIL dead_ctrl got rst=%b frz=%b want 0,1", player_rst, player_freeze); end
    for (int k = 0; k < 3; k++) begin
      pulse_key(0);
      checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL retry_respawn got %0d want 1", game_state); end
      wait_state(3'd2, 40);
      hit_hazard = 1; step(); hit_hazard = 0;
    end
    checks++; if (death_count !== 16'd4) begin errors++; $display("FAIL deaths4 got %0d want 4", death_count); end
    pulse_key(0);
    wait_state(3'd2, 40);
  endtask

  task automatic test_save_point();
    logic [9:0] ex, ey;
`ifdef GAME_FLOW_SAVE_POINT_EN
    ex = 10'd321; ey = 10'd100;
`else
    ex = 10'd200; ey = 10'd556;
`endif
    pos_x = 10'd321; pos_y = 10'd100; hit_save = 1; step(); hit_save = 0;
    pos_x = 10'd7; pos_y = 10'd9;
    checks++; if (spawn_x !== ex || spawn_y !== ey || game_state !== 3'd2) begin errors++; $display("FAIL save got %0d,%0d s=%0d want %0d,%0d s=2", spawn_x, spawn_y, game_state, ex, ey); end
    hit_hazard = 1; step(); hit_hazard = 0;
    pulse_key(0);
    wait_state(3'd2, 40);
    checks++; if (spawn_x !== ex || spawn_y !== ey) begin errors++; $display("FAIL save_kept got %0d,%0d want %0d,%0d", spawn_x, spawn_y, ex, ey); end
  endtask

  task automatic test_blink();
    logic [8:0] pat;
    pat = 9'b100001111;
    hit_hazard = 1; step(); hit_hazard = 0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (overlay_blink !== pat[i]) begin errors++; $display("FAIL blink[%0d] got %b want %b", i, overlay_blink, pat[i]); end
      start_key = (i >= 1 && i <= 3);
      step();
    end
    start_key = 0;
    checks++; if (game_state !== 3'd3) begin errors++; $display("FAIL dead_ignores_start got %0d want 3", game_state); end
  endtask

  task automatic test_async_reset();
    pulse_key(0);
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL ar_entry got %0d want 1", game_state); end
    for (int i = 0; i < 7; i++) step();
    #2 rst = 1;
    #1;
    checks++; if (game_state !== 3'd0 || player_rst !== 1'b1 || player_freeze !== 1'b1) begin errors++; $display("FAIL async_ctrl got s=%0d rst=%b frz=%b want 0,1,1", game_state, player_rst, player_freeze); end
    checks++; if (death_count !== 16'd0 || overlay_blink !== 1'b0 || spawn_x !== 10'd200 || spawn_y !== 10'd556) begin errors++; $display("FAIL async_vals got d=%0d b=%b sp=%0d,%0d want 0,0,200,556", death_count, overlay_blink, spawn_x, spawn_y); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_clear();
    pulse_key(1);
    wait_state(3'd2, 40);
    pos_x = 10'd50; pos_y = 10'd60; hit_save = 1; step(); hit_save = 0;
    hit_hazard = 1; step(); hit_hazard = 0;
    pulse_key(0);
    wait_state(3'd2, 40);
    hit_goal = 1; step(); hit_goal = 0;
    checks++; if (game_state !== 3'd4 || overlay_blink !== 1'b1 || player_freeze !== 1'b1) begin errors++; $display("FAIL clear_entry got s=%0d b=%b f=%b want 4,1,1", game_state, overlay_blink, player_freeze); end
    pulse_key(0); step();
    checks++; if (game_state !== 3'd4) begin errors++; $display("FAIL clear_ignores_retry got %0d want 4", game_state); end
    pulse_key(1);
    checks++; if (game_state !== 3'd0 || player_rst !== 1'b1 || death_count !== 16'd1) begin errors++; $display("FAIL clear_to_title got s=%0d r=%b d=%0d want 0,1,1", game_state, player_rst, death_count); end
    step();
    pulse_key(1);
    checks++; if (game_state !== 3'd1 || death_count !== 16'd0 || spawn_x !== 10'd200 || spawn_y !== 10'd556) begin errors++; $display("FAIL restart got s=%0d d=%0d sp=%0d,%0d want 1,0,200,556", game_state, death_count, spawn_x, spawn_y); end
  endtask

  task automatic test_random();
    logic [41:0] obs, expv;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) start_key = ~start_key;
      if ($urandom_range(0, 4) == 0) retry_key = ~retry_key;
      hit_hazard = ($urandom_range(0, 39) == 0);
      hit_goal   = ($urandom_range(0, 59) == 0);
      hit_save   = ($urandom_range(0, 7) == 0);
      pos_x = 10'($urandom); pos_y = 10'($urandom);
      step();
      obs  = {game_state, player_rst, player_freeze, spawn_x, spawn_y, death_count, overlay_blink};
      expv = model_out();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_respawn();
    test_hazard_deaths();
    test_save_point();
    test_blink();
    test_async_reset();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
